// File: rtl/cz_affine_image_seq.sv
// cz_affine_image_seq: sequential R*Z (+t) image of a constrained zonotope, one fp32 multiply-add per cycle.
module cz_affine_image_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int NMAX = 4,
  parameter int NGMAX = 8,
  parameter int NCMAX = 4,
  parameter int NRMAX = 4,
  localparam int NW = $clog2(NMAX + 1),
  localparam int GW = $clog2(NGMAX + 1),
  localparam int CW = $clog2(NCMAX + 1),
  localparam int RW = $clog2(NRMAX + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic mode_i,
  input  logic [NW-1:0] z_n_i,
  input  logic [GW-1:0] z_ng_i,
  input  logic [CW-1:0] z_nc_i,
  input  logic [RW-1:0] r_nr_i,
  input  logic [NMAX-1:0][DATA_WIDTH-1:0] z_c_i,
  input  logic [NMAX-1:0][NGMAX-1:0][DATA_WIDTH-1:0] z_G_i,
  input  logic [NCMAX-1:0][NGMAX-1:0][DATA_WIDTH-1:0] z_A_i,
  input  logic [NCMAX-1:0][DATA_WIDTH-1:0] z_b_i,
  input  logic [NRMAX-1:0][NMAX-1:0][DATA_WIDTH-1:0] r_mat_i,
  input  logic [NRMAX-1:0][DATA_WIDTH-1:0] t_i,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  output logic [RW-1:0] out_n_o,
  output logic [GW-1:0] out_ng_o,
  output logic [CW-1:0] out_nc_o,
  output logic [NRMAX-1:0][DATA_WIDTH-1:0] out_c_o,
  output logic [NRMAX-1:0][NGMAX-1:0][DATA_WIDTH-1:0] out_G_o,
  output logic [NCMAX-1:0][NGMAX-1:0][DATA_WIDTH-1:0] out_A_o,
  output logic [NCMAX-1:0][DATA_WIDTH-1:0] out_b_o
);
  localparam int KI = $clog2(NMAX);
  localparam int RI = $clog2(NRMAX);
  localparam int GI = $clog2(NGMAX);

  function automatic logic signed [11:0] fp_exp(input logic [31:0] a);
    return $signed({4'b0, a[30:23] | {7'b0, ~|a[30:23]}});
  endfunction

  // value = m * 2^(e-174); normalises, handles underflow to subnormal, rounds to nearest even
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [11:0] e_in, input logic [47:0] m_in);
    logic [47:0] m;
    logic signed [11:0] e;
    logic [11:0] sh;
    logic [5:0] lz;
    logic [31:0] r;
    lz = '0;
    for (int q = 0; q < 48; q++) if (m_in[q]) lz = 6'(47 - q);
    m = m_in << lz;
    e = e_in - $signed({6'b0, lz});
    if (e < 1) begin
      sh = 12'(1 - e);
      m = (m >> sh) | 48'(|(m & ~({48{1'b1}} << sh)));
      e = '0;
    end
    r = {1'b0, e[7:0], m[46:24]} + 32'(m[23] & (m[24] | (|m[22:0])));
    return m_in == '0 ? {s, 31'b0} : e > 254 ? {s, 8'hff, 23'b0} : {s, r[30:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf;
    logic [47:0] p;
    a_nan = &a[30:23] && |a[22:0];
    b_nan = &b[30:23] && |b[22:0];
    a_inf = &a[30:23] && ~|a[22:0];
    b_inf = &b[30:23] && ~|b[22:0];
    p = 48'({|a[30:23], a[22:0]}) * 48'({|b[30:23], b[22:0]});
    return (a_nan || b_nan || (a_inf && ~|b[30:0]) || (b_inf && ~|a[30:0])) ? 32'h7fc00000 :
           (a_inf || b_inf) ? {a[31] ^ b[31], 8'hff, 23'b0} :
           fp_pack(a[31] ^ b[31], fp_exp(a) + fp_exp(b) - 12'sd126, p);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [11:0] d;
    logic [47:0] ax, ay0, ay, sm;
    x = (a[30:0] < b[30:0]) ? b : a;
    y = (a[30:0] < b[30:0]) ? a : b;
    d = fp_exp(x) - fp_exp(y);
    ax = {1'b0, |x[30:23], x[22:0], 23'b0};
    ay0 = {1'b0, |y[30:23], y[22:0], 23'b0};
    ay = (ay0 >> d) | 48'(|(ay0 & ~({48{1'b1}} << d)));
    sm = (x[31] == y[31]) ? ax + ay : ax - ay;
    return ((&x[30:23] && |x[22:0]) || (&y[30:23] && |y[22:0]) || (&y[30:23] && x[31] != y[31])) ? 32'h7fc00000 :
           &x[30:23] ? x : fp_pack(sm == '0 ? x[31] & y[31] : x[31], fp_exp(x) + 12'sd1, sm);
  endfunction

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, nxt;

  logic [NMAX-1:0][DATA_WIDTH-1:0] c_q;
  logic [NMAX-1:0][NGMAX-1:0][DATA_WIDTH-1:0] g_q;
  logic [NCMAX-1:0][NGMAX-1:0][DATA_WIDTH-1:0] a_q;
  logic [NCMAX-1:0][DATA_WIDTH-1:0] b_q;
  logic [NRMAX-1:0][NMAX-1:0][DATA_WIDTH-1:0] r_q;
  logic [NRMAX-1:0][DATA_WIDTH-1:0] t_q;
  logic [NW-1:0] n_q;
  logic [GW-1:0] ng_q;
  logic [CW-1:0] nc_q;
  logic [RW-1:0] nr_q;
  logic mode_q;
  logic [RI-1:0] i;
  logic [GW-1:0] j;
  logic [KI-1:0] k;
  logic [GI-1:0] jg;
  logic [31:0] acc, acc_in, x, sum;
  logic bad, last_k, last_j, last_i;

  always_comb begin
    bad = z_n_i == '0 || r_nr_i == '0 || z_n_i > NW'(NMAX) || z_ng_i > GW'(NGMAX) ||
          z_nc_i > CW'(NCMAX) || r_nr_i > RW'(NRMAX);
    jg = GI'(j - GW'(1));
    x = (j == '0) ? c_q[k] : g_q[k][jg];
    acc_in = (k != '0) ? acc : (j == '0 && mode_q) ? t_q[i] : '0;
    sum = fp_add(acc_in, fp_mul(r_q[i][k], x));
    last_k = NW'(k) == n_q - NW'(1);
    last_j = j == ng_q;
    last_i = RW'(i) == nr_q - RW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start_i) nxt = bad ? DONE : MAC;
      MAC: if (last_k && last_j && last_i) nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  assign busy_o = state != IDLE;
  assign done_o = state == DONE;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      {c_q, g_q, a_q, b_q, r_q, t_q, n_q, ng_q, nc_q, nr_q, mode_q} <= '0;
      {i, j, k, acc, err_o} <= '0;
      {out_n_o, out_ng_o, out_nc_o, out_c_o, out_G_o, out_A_o, out_b_o} <= '0;
    end else if (state == IDLE && start_i) begin
      {c_q, g_q, r_q, t_q} <= {z_c_i, z_G_i, r_mat_i, t_i};
      {n_q, ng_q, nc_q, nr_q, mode_q} <= {z_n_i, z_ng_i, z_nc_i, r_nr_i, mode_i};
      // constraints are masked at capture so the pass-through copy is already zero-padded
      for (int r = 0; r < NCMAX; r++) begin
        b_q[r] <= (CW'(r) < z_nc_i) ? z_b_i[r] : '0;
        for (int c = 0; c < NGMAX; c++)
          a_q[r][c] <= (CW'(r) < z_nc_i && GW'(c) < z_ng_i) ? z_A_i[r][c] : '0;
      end
      {i, j, k, acc} <= '0;
      err_o <= bad;
      {out_n_o, out_ng_o, out_nc_o, out_c_o, out_G_o, out_A_o, out_b_o} <= '0;
    end else if (state == MAC) begin
      acc <= sum;
      k <= last_k ? '0 : k + KI'(1);
      if (last_k) begin
        j <= last_j ? '0 : j + GW'(1);
        i <= last_j ? i + RI'(1) : i;
        if (j == '0) out_c_o[i] <= sum;
        else out_G_o[i][jg] <= sum;
      end
      if (last_k && last_j && last_i)
        {out_n_o, out_ng_o, out_nc_o, out_A_o, out_b_o} <= {nr_q, ng_q, nc_q, a_q, b_q};
    end
endmodule

// File: tb/tb_cz_affine_image_seq.sv
// tb_cz_affine_image_seq: directed and randomized checks of cz_affine_image_seq against a real-arithmetic model.
module tb_cz_affine_image_seq;
  localparam int NMAX = 4, NGMAX = 8, NCMAX = 4, NRMAX = 4;
  localparam logic [3:0][31:0] SPEC_C = {64'h0, 32'h3f800000, 32'h40a00000};
  localparam logic [7:0][31:0] SPEC_G0 = {160'h0, 32'hbf000000, 32'h3f800000, 32'h3f000000};
  localparam logic [7:0][31:0] SPEC_G1 = {160'h0, 32'h00000000, 32'h3f800000, 32'h3f800000};

  logic clk_tb = 0, rst_tb, start, mode;
  logic [2:0] z_n, z_nc, r_nr, o_n, o_nc;
  logic [3:0] z_ng, o_ng;
  logic [3:0][31:0] z_c, z_b, t, o_c, o_b, exp_c, exp_b;
  logic [3:0][7:0][31:0] z_g, z_a, o_g, o_a, exp_g, exp_a;
  logic [3:0][3:0][31:0] r_mat;
  logic busy, done, err;
  int total = 0, bad = 0;

  cz_affine_image_seq dut (
    .clk_i(clk_tb), .rst_i(rst_tb), .start_i(start), .mode_i(mode),
    .z_n_i(z_n), .z_ng_i(z_ng), .z_nc_i(z_nc), .r_nr_i(r_nr),
    .z_c_i(z_c), .z_G_i(z_g), .z_A_i(z_a), .z_b_i(z_b), .r_mat_i(r_mat), .t_i(t),
    .busy_o(busy), .done_o(done), .err_o(err),
    .out_n_o(o_n), .out_ng_o(o_ng), .out_nc_o(o_nc),
    .out_c_o(o_c), .out_G_o(o_g), .out_A_o(o_a), .out_b_o(o_b)
  );

  always #5 clk_tb = ~clk_tb;

  function automatic real to_r(input logic [31:0] f);
    logic [63:0] d;
    d = (f[30:0] == 0) ? {f[31], 63'b0} : {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // double -> binary32 with round-to-nearest-even (normal range only)
  function automatic logic [31:0] to_f(input real v);
    logic [63:0] d;
    logic [24:0] m;
    int e;
    d = $realtobits(v);
    if (d[62:0] == 0) return {d[63], 31'b0};
    e = int'(d[62:52]) - 1023 + 127;
    m = {2'b01, d[51:29]} + 25'(d[28] & (d[29] | (|d[27:0])));
    if (m[24]) begin
      e++;
      m = m >> 1;
    end
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rv();
    logic [31:0] v;
    v = {1'($urandom), 8'(123 + $urandom_range(0, 8)), 23'($urandom)};
    return ($urandom_range(0, 7) == 0) ? 32'h0 : v;
  endfunction

  // every product and running sum is exact in double here, so one rounding per step matches fp32
  task automatic model();
    logic [31:0] acc, x;
    {exp_c, exp_g, exp_a, exp_b} = '0;
    for (int i = 0; i < int'(r_nr); i++)
      for (int j = 0; j <= int'(z_ng); j++) begin
        acc = (j == 0 && mode) ? t[i] : 32'h0;
        for (int k = 0; k < int'(z_n); k++) begin
          x = (j == 0) ? z_c[k] : z_g[k][j-1];
          acc = to_f(to_r(acc) + to_r(to_f(to_r(r_mat[i][k]) * to_r(x))));
        end
        if (j == 0) exp_c[i] = acc;
        else exp_g[i][j-1] = acc;
      end
    for (int r = 0; r < int'(z_nc); r++) begin
      exp_b[r] = z_b[r];
      for (int c = 0; c < int'(z_ng); c++) exp_a[r][c] = z_a[r][c];
    end
  endtask

  task automatic load_spec(input logic md);
    {z_n, z_ng, z_nc, r_nr, mode} = {3'd2, 4'd3, 3'd1, 3'd2, md};
    z_c = {4{32'h41200000}};
    z_g = {32{32'h41200000}};
    r_mat = {16{32'h40400000}};
    t = {4{32'h41200000}};
    z_a = {32{32'h12345678}};
    z_b = {4{32'h12345678}};
    z_c[0] = 32'h40a00000; z_c[1] = 32'h3f000000;
    z_g[0][2:0] = {32'hbf000000, 32'h3f800000, 32'h3f000000};
    z_g[1][2:0] = {32'h00000000, 32'h3f000000, 32'h3f000000};
    r_mat[0][1:0] = {32'h0, 32'h3f800000};
    r_mat[1][1:0] = {32'h40000000, 32'h0};
    t[1:0] = {32'hbf800000, 32'h3f800000};
    z_a[0][2:0] = {32'hbf000000, 32'h3f800000, 32'h3f000000};
    z_b[0] = 32'h3f800000;
  endtask

  task automatic kick(output int lat);
    @(negedge clk_tb) start = 1;
    @(negedge clk_tb) start = 0;
    lat = -1;
    for (int c = 0; c < 300; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk_tb);
    end
  endtask

  task automatic test_reset();
    rst_tb = 1;
    repeat (2) @(negedge clk_tb);
    total += 3;
    if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL rst_flags got %b exp 000", {busy, done, err}); end
    if ({o_n, o_ng, o_nc, o_c} !== '0) begin bad++; $display("FAIL rst_c got %h exp 0", o_c); end
    if ({o_g, o_a, o_b} !== '0) begin bad++; $display("FAIL rst_data got nonzero exp 0"); end
    rst_tb = 0;
  endtask

  task automatic test_linear();
    int lat;
    load_spec(0);
    kick(lat);
    total += 9;
    if (lat !== 16) begin bad++; $display("FAIL lin_lat got %0d exp 16", lat); end
    if (o_c !== SPEC_C) begin bad++; $display("FAIL lin_c got %h exp %h", o_c, SPEC_C); end
    if (o_g[0] !== SPEC_G0) begin bad++; $display("FAIL lin_g0 got %h exp %h", o_g[0], SPEC_G0); end
    if (o_g[1] !== SPEC_G1) begin bad++; $display("FAIL lin_g1 got %h exp %h", o_g[1], SPEC_G1); end
    if ({o_g[3:2], o_a[3:1]} !== '0) begin bad++; $display("FAIL lin_pad got nonzero exp 0"); end
    if (o_a[0] !== SPEC_G0) begin bad++; $display("FAIL lin_a got %h exp %h", o_a[0], SPEC_G0); end
    if (o_b !== 128'h3f800000) begin bad++; $display("FAIL lin_b got %h exp %h", o_b, 128'h3f800000); end
    if ({o_n, o_ng, o_nc, err, busy} !== {3'd2, 4'd3, 3'd1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL lin_sizes got %0d %0d %0d err=%b busy=%b exp 2 3 1 err=0 busy=1", o_n, o_ng, o_nc, err, busy);
    end
    @(negedge clk_tb);
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL lin_pulse got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_affine();
    int lat;
    load_spec(1);
    kick(lat);
    total += 4;
    if (lat !== 16) begin bad++; $display("FAIL aff_lat got %0d exp 16", lat); end
    if (o_c !== {64'h0, 32'h00000000, 32'h40c00000}) begin bad++; $display("FAIL aff_c got %h exp 40c00000 in [0], 0 in [1]", o_c); end
    if ({o_g[1], o_g[0]} !== {SPEC_G1, SPEC_G0}) begin bad++; $display("FAIL aff_g got %h exp %h", {o_g[1], o_g[0]}, {SPEC_G1, SPEC_G0}); end
    if (err !== 1'b0) begin bad++; $display("FAIL aff_err got %b exp 0", err); end
  endtask

  task automatic test_nonsquare();
    int lat;
    load_spec(0);
    r_nr = 1;
    r_mat[0][1] = 32'h3f800000;
    kick(lat);
    total += 4;
    if (lat !== 8) begin bad++; $display("FAIL nsq_lat got %0d exp 8", lat); end
    if (o_c !== 128'h40b00000) begin bad++; $display("FAIL nsq_c got %h exp %h", o_c, 128'h40b00000); end
    if ({o_g[1], o_g[0]} !== {256'h0, 160'h0, 32'hbf000000, 32'h3fc00000, 32'h3f800000}) begin
      bad++; $display("FAIL nsq_g got %h", {o_g[1], o_g[0]});
    end
    if (o_n !== 3'd1) begin bad++; $display("FAIL nsq_n got %0d exp 1", o_n); end
  endtask

  task automatic test_error();
    int lat;
    load_spec(0);
    z_ng = 4'd9;
    kick(lat);
    total += 6;
    if (lat !== 0) begin bad++; $display("FAIL err_lat got %0d exp 0", lat); end
    if ({err, busy} !== 2'b11) begin bad++; $display("FAIL err_flags got err=%b busy=%b exp 1 1", err, busy); end
    if ({o_n, o_ng, o_nc, o_c, o_b} !== '0 || {o_g, o_a} !== '0) begin bad++; $display("FAIL err_zero got c=%h exp 0", o_c); end
    @(negedge clk_tb);
    if ({err, busy, done} !== 3'b100) begin bad++; $display("FAIL err_hold got err=%b busy=%b done=%b exp 1 0 0", err, busy, done); end
    z_ng = 4'd3;
    kick(lat);
    if ({err, lat} !== {1'b0, 32'd16}) begin bad++; $display("FAIL err_clear got err=%b lat=%0d exp 0 16", err, lat); end
    if (o_c !== SPEC_C) begin bad++; $display("FAIL err_clear_c got %h exp %h", o_c, SPEC_C); end
  endtask

  task automatic test_start_held();
    int lat, lat2;
    load_spec(0);
    @(negedge clk_tb) start = 1;
    @(negedge clk_tb);
    z_c[0] = 32'h41000000;
    z_g[0][0] = 32'h40000000;
    mode = 1;
    r_mat[1][1] = 32'h3f800000;
    lat = -1;
    for (int c = 0; c < 300; c++) begin
      if (done) begin lat = c; break; end
      @(negedge clk_tb);
    end
    total += 6;
    if (lat !== 16) begin bad++; $display("FAIL held_lat got %0d exp 16", lat); end
    if (o_c !== SPEC_C) begin bad++; $display("FAIL held_c got %h exp %h", o_c, SPEC_C); end
    if ({o_g[1], o_g[0]} !== {SPEC_G1, SPEC_G0}) begin bad++; $display("FAIL held_g got %h", {o_g[1], o_g[0]}); end
    @(negedge clk_tb);
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL held_idle got done=%b busy=%b exp 0 0", done, busy); end
    @(negedge clk_tb);
    if (busy !== 1'b1) begin bad++; $display("FAIL held_restart got busy=%b exp 1", busy); end
    start = 0;
    model();
    lat2 = -1;
    for (int c = 0; c < 300; c++) begin
      if (done) begin lat2 = c; break; end
      @(negedge clk_tb);
    end
    if ({lat2, o_c} !== {32'd16, exp_c}) begin bad++; $display("FAIL held_second got lat=%0d c=%h exp 16 %h", lat2, o_c, exp_c); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    load_spec(0);
    @(negedge clk_tb) start = 1;
    @(negedge clk_tb) start = 0;
    repeat (6) @(negedge clk_tb);
    rst_tb = 1;
    #1;
    total += 5;
    if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL mid_flags got %b exp 000", {busy, done, err}); end
    if ({o_n, o_ng, o_nc, o_c, o_g} !== '0) begin bad++; $display("FAIL mid_zero got c=%h exp 0", o_c); end
    @(negedge clk_tb) rst_tb = 0;
    seen = 0;
    repeat (20) begin
      @(negedge clk_tb);
      if (done) seen = 1;
    end
    if (seen !== 1'b0) begin bad++; $display("FAIL mid_nodone got %b exp 0", seen); end
    kick(lat);
    if (lat !== 16) begin bad++; $display("FAIL mid_lat got %0d exp 16", lat); end
    if ({o_g[1], o_g[0], o_c} !== {SPEC_G1, SPEC_G0, SPEC_C}) begin bad++; $display("FAIL mid_fresh got c=%h exp %h", o_c, SPEC_C); end
  endtask

  task automatic test_random();
    int lat, want;
    for (int it = 0; it < 25; it++) begin
      z_n = 3'($urandom_range(1, 4));
      z_ng = 4'($urandom_range(0, 8));
      z_nc = 3'($urandom_range(0, 4));
      r_nr = 3'($urandom_range(1, 4));
      mode = 1'($urandom);
      for (int a = 0; a < 4; a++) begin
        {z_c[a], z_b[a], t[a]} = {rv(), rv(), rv()};
        for (int b = 0; b < 4; b++) r_mat[a][b] = rv();
        for (int b = 0; b < 8; b++) {z_g[a][b], z_a[a][b]} = {rv(), rv()};
      end
      model();
      want = int'(r_nr) * (int'(z_ng) + 1) * int'(z_n);
      kick(lat);
      total += 4;
      if (lat !== want) begin bad++; $display("FAIL rnd%0d_lat got %0d exp %0d", it, lat, want); end
      if ({o_c, o_b} !== {exp_c, exp_b}) begin bad++; $display("FAIL rnd%0d_cb got %h exp %h", it, {o_c, o_b}, {exp_c, exp_b}); end
      if ({o_n, o_ng, o_nc, err} !== {r_nr, z_ng, z_nc, 1'b0}) begin
        bad++; $display("FAIL rnd%0d_sizes got %0d %0d %0d err=%b exp %0d %0d %0d", it, o_n, o_ng, o_nc, err, r_nr, z_ng, z_nc);
      end
      for (int r = 0; r < 4; r++) begin
        total += 2;
        if (o_g[r] !== exp_g[r]) begin bad++; $display("FAIL rnd%0d_g%0d got %h exp %h", it, r, o_g[r], exp_g[r]); end
        if (o_a[r] !== exp_a[r]) begin bad++; $display("FAIL rnd%0d_a%0d got %h exp %h", it, r, o_a[r], exp_a[r]); end
      end
    end
  endtask

  initial begin
    start = 0;
    mode = 0;
    load_spec(0);
    test_reset();
    test_linear();
    test_affine();
    test_nonsquare();
    test_error();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cz_affine_image_seq.md
# cz_affine_image_seq

Sequential, parametrised successor to the combinational linear-image operator for constrained zonotopes. It computes OUT = R·Z (linear mode) or OUT = R·Z + t (affine mode), one IEEE-754 single-precision multiply-add per cycle, with a start/busy/done handshake. The engine sits beside `plus`/`intersection` in the set-operation datapath and replaces the single-shot linear image wherever NMAX/NGMAX/NRMAX grow beyond what a full combinational array can close timing on.

## Interface
- DATA_WIDTH, 32: word width; IEEE-754 binary32 only.
- NMAX, 4: max state dimension n of Z.
- NGMAX, 8: max generator count ng.
- NCMAX, 4: max constraint count nc.
- NRMAX, 4: max rows nr of R (output dimension).
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request; sampled only in IDLE.
- mode_i  in  1  0 = linear R·Z, 1 = affine R·Z + t.
- z_n_i, z_ng_i, z_nc_i, r_nr_i  in  $clog2(max+1) each  active sizes.
- z_c_i  in  [NMAX] x DATA_WIDTH  center.
- z_G_i  in  [NMAX][NGMAX] x DATA_WIDTH  generators.
- z_A_i  in  [NCMAX][NGMAX] x DATA_WIDTH, z_b_i  in  [NCMAX] x DATA_WIDTH  constraints.
- r_mat_i  in  [NRMAX][NMAX] x DATA_WIDTH  map R.
- t_i  in  [NRMAX] x DATA_WIDTH  translation (affine mode only).
- busy_o  out  1  engine not in IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  dimension error; valid with done_o, held until next accepted start.
- out_n_o, out_ng_o, out_nc_o  out  sizes: nr, ng, nc.
- out_c_o [NRMAX], out_G_o [NRMAX][NGMAX], out_A_o [NCMAX][NGMAX], out_b_o [NCMAX]  out  result.

## Operation
- States: IDLE, MAC, DONE.
- IDLE + start_i: latch all inputs and mode; clear all outputs and err_o to zero. If n==0, nr==0, n>NMAX, ng>NGMAX, nc>NCMAX or nr>NRMAX -> err_o=1, go DONE. Otherwise go MAC.
- MAC: loops row i = 0..nr-1 (outer), column j = 0..ng (column 0 = center, j>=1 = G column j-1), k = 0..n-1 (inner). One product R[i][k]·X[k][j] per cycle.
- Accumulator init per element: +0.0, except center element in affine mode, which starts at t[i]. acc = fp_add(acc, fp_mul(R[i][k], X[k][j])) strictly in k order; round-to-nearest-even, no fused MAC; uses existing fp32 mul/add units (combinational).
- At k==n-1, the element is written to out_c_o[i] / out_G_o[i][j-1]; after the last element -> DONE.
- Pass-through: out_A_o, out_b_o, out_nc_o copied from latched values at the MAC->DONE transition; out_n_o=nr, out_ng_o=ng.
- Entries beyond active sizes stay zero. On error, all data outputs and sizes stay zero.
- DONE: done_o=1 for one cycle, then IDLE. Outputs hold until next accepted start.
- start_i while busy_o=1 (including the DONE cycle) is ignored; not queued.
- Input ports may change freely after the start edge; only latched copies are used.

## Timing
- Reset (asynchronous, any state): state IDLE; busy_o, done_o, err_o = 0; all outputs and sizes = 0; loop counters and accumulator = 0.
- Start accepted at edge E0; busy_o=1 after E0.
- Normal: M = nr·(ng+1)·n MAC cycles; last element is written at edge EM; done_o high during cycle EM..EM+1; busy_o falls after EM+1.
- Error: DONE entered at E0; done_o and err_o visible after E0; busy_o high for that single cycle.
- Earliest next accepted start: edge after done_o drops.
- Reset asserted mid-MAC: partial results discarded, no done_o pulse.

## Test plan
- Linear, R=diag(1.0,2.0), n=2, ng=3, nc=1, c=(40a00000,3f000000), G=[[3f000000,3f800000,bf000000],[3f000000,3f000000,0]], A=[3f000000,3f800000,bf000000], b=3f800000 -> c=(40a00000,3f800000), G row1=(3f800000,3f800000,00000000), row0 unchanged, A/b copied, sizes (2,3,1); done_o exactly 16 cycles after start.
- Same Z and R, mode_i=1, t=(3f800000,bf800000) -> c=(40c00000,00000000), G as above, err_o=0.
- Non-square nr=1, R=[3f800000,3f800000] -> c=40b00000, G=(3f800000,3fc00000,bf000000), out_n_o=1; done after 8 cycles.
- z_ng_i=NGMAX+1 -> err_o=1, done_o one cycle after start, all outputs zero; next valid start clears err_o.
- start_i held high through a run, inputs changed after E0 -> single completion, results match original inputs; second start accepted only after done.
- rst_i pulsed mid-MAC (cycle 7) -> all outputs zero immediately, no done_o; fresh start gives correct results.
